// File: rtl/lsu64_rmw.sv
// rtl/lsu64_rmw.sv - sequential 64-bit load/store read-modify-write sequencer
module lsu64_rmw #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [2:0]            req_funct3,
    input  logic [63:0]           req_store_value,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_efault,
    output logic [63:0]           resp_load_value,
    output logic [ADDR_WIDTH-4:0] ram_address,
    output logic                  ram_read_enable,
    input  logic [63:0]           ram_read_data,
    output logic                  ram_write_enable,
    output logic [63:0]           ram_write_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                  state;
    logic                    store_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              funct3_q;
    logic [63:0]             store_value_q;
    logic                    efault_q;
    logic [63:0]             load_q;
    logic [63:0]             wdata_q;

    logic                    req_fault;
    logic [63:0]             shifted;
    logic [63:0]             load_ext;
    logic [63:0]             replicated;
    logic [7:0]              byte_mask;
    logic [63:0]             merged;

    // Alignment fault decision on the request being accepted this cycle.
    always_comb begin
        req_fault = 1'b0;
        case (req_funct3[1:0])
            2'b00: req_fault = 1'b0;
            2'b01: req_fault = req_address[0];
            2'b10: req_fault = |req_address[1:0];
            2'b11: req_fault = (|req_address[2:0]) || req_funct3[2];
            default: req_fault = 1'b0;
        endcase
        if (req_store && req_funct3[2]) begin
            req_fault = 1'b1;
        end
    end

    // Load path: bring the addressed bytes down to bit 0, then sign/zero extend.
    always_comb begin
        shifted  = ram_read_data >> {addr_q[2:0], 3'b000};
        load_ext = shifted;
        case (funct3_q[1:0])
            2'b00: load_ext = {{56{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = {{48{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            2'b10: load_ext = {{32{~funct3_q[2] & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Store path: replicate the store datum over every lane and pick lanes by byte mask.
    always_comb begin
        replicated = store_value_q;
        byte_mask  = 8'hff;
        case (funct3_q[1:0])
            2'b00: begin
                replicated = {8{store_value_q[7:0]}};
                byte_mask  = 8'h01 << addr_q[2:0];
            end
            2'b01: begin
                replicated = {4{store_value_q[15:0]}};
                byte_mask  = 8'h03 << addr_q[2:0];
            end
            2'b10: begin
                replicated = {2{store_value_q[31:0]}};
                byte_mask  = 8'h0f << addr_q[2:0];
            end
            default: begin
                replicated = store_value_q;
                byte_mask  = 8'hff;
            end
        endcase
        merged = ram_read_data;
        for (int i = 0; i < 8; i++) begin
            if (byte_mask[i]) begin
                merged[8*i +: 8] = replicated[8*i +: 8];
            end
        end
    end

    // Sequencer: accept, read, extract or merge, optional write-back, respond.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            store_q       <= 1'b0;
            addr_q        <= '0;
            funct3_q      <= 3'b000;
            store_value_q <= 64'd0;
            efault_q      <= 1'b0;
            load_q        <= 64'd0;
            wdata_q       <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q       <= req_store;
                        addr_q        <= req_address;
                        funct3_q      <= req_funct3;
                        store_value_q <= req_store_value;
                        efault_q      <= req_fault;
                        load_q        <= 64'd0;
                        state         <= req_fault ? S_RESP : S_READ;
                    end
                end
                S_READ: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (store_q) begin
                        wdata_q <= merged;
                        state   <= S_WRITE;
                    end else begin
                        load_q <= load_ext;
                        state  <= S_RESP;
                    end
                end
                S_WRITE: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state and are forced low while reset is high.
    always_comb begin
        req_ready        = !reset && (state == S_IDLE);
        resp_valid       = !reset && (state == S_RESP);
        resp_efault      = resp_valid && efault_q;
        resp_load_value  = resp_valid ? load_q : 64'd0;
        ram_address      = reset ? '0 : addr_q[ADDR_WIDTH-1:3];
        ram_read_enable  = !reset && (state == S_READ);
        ram_write_enable = !reset && (state == S_WRITE);
        ram_write_data   = ram_write_enable ? wdata_q : 64'd0;
    end

endmodule
